// File: rtl/spi_voice_regs_if.sv
// spi_voice_regs_if: SPI pin bundle between an SPI master and the voice register file.
interface spi_voice_regs_if;
    logic sclk;
    logic nss;
    logic mosi;
    logic miso;
    modport master (output sclk, output nss, output mosi, input miso);
    modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_voice_regs.sv
// spi_voice_regs: multi-voice SPI register file, SPI pins oversampled in the clk domain.
module spi_voice_regs #(
    parameter int NUM_VOICES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_voice_regs_if.slave          spi,
    output logic [8*NUM_VOICES-1:0]  adsr_ai_o,
    output logic [8*NUM_VOICES-1:0]  adsr_di_o,
    output logic [8*NUM_VOICES-1:0]  adsr_s_o,
    output logic [8*NUM_VOICES-1:0]  adsr_ri_o,
    output logic [32*NUM_VOICES-1:0] osc_count_o,
    output logic [16*NUM_VOICES-1:0] filter_a_o,
    output logic [16*NUM_VOICES-1:0] filter_b_o,
    output logic [NUM_VOICES-1:0]    mute_o,
    output logic [NUM_VOICES-1:0]    trig_o,
    output logic                     frame_err_o
);
    typedef enum logic [2:0] {ARMED, IDLE, CMD, DATA, DONE, ERR} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, nss_sync_q, mosi_sync_q;
    logic sclk_prev_q, nss_prev_q;
    logic s_sclk, s_nss, s_mosi, sclk_rise, sclk_fall, nss_rise, nss_fall;
    logic [5:0] cnt_q;
    logic [7:0] cmd_q;
    logic [31:0] data_q, tx_q, rd_word;
    logic [6:0] nxt_cmd;
    logic miso_q, frame_err_q;
    logic [NUM_VOICES-1:0] mute_q, trig_q;
    logic [7:0] ai_q [NUM_VOICES];
    logic [7:0] di_q [NUM_VOICES];
    logic [7:0] s_q [NUM_VOICES];
    logic [7:0] ri_q [NUM_VOICES];
    logic [31:0] osc_q [NUM_VOICES];
    logic [15:0] fa_q [NUM_VOICES];
    logic [15:0] fb_q [NUM_VOICES];
    logic shift_cmd, shift_dat, load_tx, commit, err, cnt_inc, cnt_clr, miso_en;
    // nss chain resets low so a frame still in progress at release keeps the FSM in ARMED
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            nss_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            nss_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi.nss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev_q <= s_sclk;
            nss_prev_q  <= s_nss;
        end
    end
    assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
    assign s_nss     = nss_sync_q[SYNC_STAGES-1];
    assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_prev_q;
    assign sclk_fall = ~s_sclk & sclk_prev_q;
    assign nss_rise  = s_nss & ~nss_prev_q;
    assign nss_fall  = ~s_nss & nss_prev_q;
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ARMED;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED:   state_d = s_nss ? IDLE : ARMED;
            IDLE:    state_d = nss_fall ? CMD : IDLE;
            CMD:     state_d = nss_rise ? IDLE : (sclk_rise && cnt_q == 6'd7) ? DATA : CMD;
            DATA:    state_d = nss_rise ? IDLE : (sclk_rise && cnt_q == 6'd39) ? DONE : DATA;
            DONE:    state_d = nss_rise ? IDLE : sclk_rise ? ERR : DONE;
            ERR:     state_d = nss_rise ? IDLE : ERR;
            default: state_d = ARMED;
        endcase
    end
    // nss rise outranks a simultaneous sclk rise: that bit is never shifted or counted
    always_comb begin
        shift_cmd = state_q == CMD && sclk_rise && !nss_rise;
        shift_dat = state_q == DATA && sclk_rise && !nss_rise;
        load_tx   = shift_cmd && cnt_q == 6'd7;
        commit    = state_q == DONE && nss_rise && !cmd_q[7];
        err       = nss_rise && (state_q == CMD || state_q == DATA || state_q == ERR);
        cnt_inc   = sclk_rise && !nss_rise && (state_q == CMD || state_q == DATA || state_q == DONE || state_q == ERR);
        cnt_clr   = state_q == IDLE;
        miso_en   = state_q == DATA && cmd_q[7];
    end
    assign nxt_cmd = {cmd_q[5:0], s_mosi};
    always_comb begin
        rd_word = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (nxt_cmd[6:2] == 5'(v))
                rd_word = nxt_cmd[1:0] == 2'd0 ? {ai_q[v], di_q[v], s_q[v], ri_q[v]} :
                          nxt_cmd[1:0] == 2'd1 ? osc_q[v] :
                          nxt_cmd[1:0] == 2'd2 ? {fa_q[v], fb_q[v]} : {31'b0, mute_q[v]};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            trig_q      <= '0;
            mute_q      <= '1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                ai_q[v]  <= '0;
                di_q[v]  <= '0;
                s_q[v]   <= '0;
                ri_q[v]  <= '0;
                osc_q[v] <= '0;
                fa_q[v]  <= '0;
                fb_q[v]  <= '0;
            end
        end else begin
            cnt_q       <= cnt_clr ? '0 : (cnt_inc && cnt_q != 6'h3f) ? cnt_q + 6'd1 : cnt_q;
            cmd_q       <= shift_cmd ? {cmd_q[6:0], s_mosi} : cmd_q;
            data_q      <= shift_dat ? {data_q[30:0], s_mosi} : data_q;
            tx_q        <= load_tx ? rd_word : (miso_en && sclk_fall) ? {tx_q[30:0], 1'b0} : tx_q;
            miso_q      <= miso_en ? (sclk_fall ? tx_q[31] : miso_q) : 1'b0;
            frame_err_q <= err;
            trig_q      <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (commit && cmd_q[6:2] == 5'(v)) begin
                    if (cmd_q[1:0] == 2'd0) {ai_q[v], di_q[v], s_q[v], ri_q[v]} <= data_q;
                    if (cmd_q[1:0] == 2'd1) osc_q[v] <= data_q;
                    if (cmd_q[1:0] == 2'd2) {fa_q[v], fb_q[v]} <= data_q;
                    if (cmd_q[1:0] == 2'd3) begin
                        mute_q[v] <= data_q[0];
                        trig_q[v] <= data_q[1];
                    end
                end
            end
        end
    end
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign adsr_ai_o[8*v +: 8]    = ai_q[v];
        assign adsr_di_o[8*v +: 8]    = di_q[v];
        assign adsr_s_o[8*v +: 8]     = s_q[v];
        assign adsr_ri_o[8*v +: 8]    = ri_q[v];
        assign osc_count_o[32*v +: 32] = osc_q[v];
        assign filter_a_o[16*v +: 16] = fa_q[v];
        assign filter_b_o[16*v +: 16] = fb_q[v];
    end
    assign mute_o      = mute_q;
    assign trig_o      = trig_q;
    assign frame_err_o = frame_err_q;
    assign spi.miso    = miso_q;
endmodule

// File: tb/tb_spi_voice_regs.sv
// tb_spi_voice_regs: directed SPI frames against spi_voice_regs with hand-computed expectations.
module tb_spi_voice_regs;
    localparam int HALF = 80;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    spi_voice_regs_if spi();
    logic [31:0] ai, di, sl, ri;
    logic [127:0] osc;
    logic [63:0] fa, fb;
    logic [3:0] mute, trig;
    logic ferr;
    spi_voice_regs dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .adsr_ai_o(ai), .adsr_di_o(di), .adsr_s_o(sl), .adsr_ri_o(ri),
        .osc_count_o(osc), .filter_a_o(fa), .filter_b_o(fb),
        .mute_o(mute), .trig_o(trig), .frame_err_o(ferr)
    );
    int trig_cycles = 0;
    int ferr_cycles = 0;
    logic [3:0] trig_val = '0;
    logic [3:0] trig_mute = '0;
    always @(negedge clk) begin
        if (trig != 4'b0) begin
            trig_cycles++;
            trig_val  = trig;
            trig_mute = mute;
        end
        if (ferr) ferr_cycles++;
    end
    int npass = 0;
    int ntotal = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask
    task automatic xfer_bit(input logic b, output logic m);
        spi.mosi = b;
        #(HALF);
        spi.sclk = 1'b1;
        m = spi.miso;
        #(HALF);
        spi.sclk = 1'b0;
    endtask
    task automatic frame_body(input logic [7:0] cmd, input logic [31:0] d, input int n, output logic [31:0] rd);
        logic [39:0] w;
        logic m;
        w = {cmd, d};
        rd = '0;
        spi.nss = 1'b0;
        #(HALF);
        for (int i = 0; i < n; i++) begin
            xfer_bit(w[39], m);
            w = w << 1;
            if (i >= 8 && i < 40) rd = {rd[30:0], m};
        end
        #(HALF);
    endtask
    task automatic frame(input logic [7:0] cmd, input logic [31:0] d, input int n, output logic [31:0] rd);
        frame_body(cmd, d, n, rd);
        spi.nss = 1'b1;
        #200;
    endtask
    initial begin
        logic [31:0] rd;
        logic [39:0] w;
        logic m;
        int t0, f0;
        spi.sclk = 1'b0;
        spi.nss  = 1'b1;
        spi.mosi = 1'b0;
        repeat (5) @(negedge clk);
        chk("miso_in_reset", spi.miso, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_ai", ai, 0);
        chk("rst_osc_lo", osc[63:0], 0);
        chk("rst_osc_hi", osc[127:64], 0);
        chk("rst_fa", fa, 0);
        chk("rst_fb", fb, 0);
        chk("rst_mute", mute, 4'hF);
        chk("rst_miso", spi.miso, 0);
        chk("rst_trig", trig_cycles, 0);
        chk("rst_ferr", ferr_cycles, 0);
        // v2 reg0 write with exact commit timing around the synchronised nss rise
        frame_body(8'h08, 32'h12345678, 40, rd);
        spi.nss = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("commit_early_ai", ai, 0);
        @(posedge clk);
        #2;
        chk("commit_ai", ai, 32'h00120000);
        chk("commit_di", di, 32'h00340000);
        chk("commit_s", sl, 32'h00560000);
        chk("commit_ri", ri, 32'h00780000);
        @(negedge clk);
        #200;
        t0 = trig_cycles;
        frame(8'h07, 32'h00000002, 40, rd);
        chk("trig_len", trig_cycles - t0, 1);
        chk("trig_val", trig_val, 4'b0010);
        chk("trig_mute", trig_mute, 4'b1101);
        chk("mute_after", mute, 4'hD);
        frame(8'h87, 32'h0, 40, rd);
        chk("rd_v1_reg3", rd, 32'h0);
        frame(8'h83, 32'h0, 40, rd);
        chk("rd_v0_reg3", rd, 32'h1);
        frame(8'h01, 32'h9ABCDEF0, 40, rd);
        chk("osc_v0", osc[63:0], 64'h9ABCDEF0);
        frame(8'h81, 32'h0, 40, rd);
        chk("rd_v0_reg1", rd, 32'h9ABCDEF0);
        frame(8'h9D, 32'h0, 40, rd);
        chk("rd_v7", rd, 32'h0);
        frame(8'h88, 32'h0, 40, rd);
        chk("rd_v2_reg0", rd, 32'h12345678);
        frame(8'h0E, 32'hAAAA5555, 40, rd);
        chk("fa_v3", fa, 64'hAAAA_0000_0000_0000);
        chk("fb_v3", fb, 64'h5555_0000_0000_0000);
        frame(8'h1D, 32'hFFFFFFFF, 40, rd);
        chk("v7_write_lo", osc[63:0], 64'h9ABCDEF0);
        chk("v7_write_hi", osc[127:64], 0);
        chk("no_ferr_valid", ferr_cycles, 0);
        chk("miso_idle", spi.miso, 0);
        f0 = ferr_cycles;
        frame(8'h01, 32'h0, 20, rd);
        chk("abort_ferr", ferr_cycles - f0, 1);
        chk("abort_osc", osc[63:0], 64'h9ABCDEF0);
        frame(8'h01, 32'h0, 41, rd);
        chk("long_ferr", ferr_cycles - f0, 2);
        chk("long_osc", osc[63:0], 64'h9ABCDEF0);
        chk("long_mute", mute, 4'hD);
        // reset asserted mid-frame and released while nss is still low
        f0 = ferr_cycles;
        t0 = trig_cycles;
        w = {8'h01, 32'h11111111};
        spi.nss = 1'b0;
        #(HALF);
        for (int i = 0; i < 10; i++) begin
            xfer_bit(w[39], m);
            w = w << 1;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 10; i < 40; i++) begin
            xfer_bit(w[39], m);
            w = w << 1;
        end
        #(HALF);
        spi.nss = 1'b1;
        #200;
        chk("midrst_osc", osc[63:0], 0);
        chk("midrst_ai", ai, 0);
        chk("midrst_mute", mute, 4'hF);
        chk("midrst_ferr", ferr_cycles - f0, 0);
        chk("midrst_trig", trig_cycles - t0, 0);
        frame(8'h01, 32'h55AA55AA, 40, rd);
        chk("post_rst_osc", osc[63:0], 64'h55AA55AA);
        frame(8'h81, 32'h0, 40, rd);
        chk("post_rst_rd", rd, 32'h55AA55AA);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
